// File: rtl/usbp_host_bridge.sv
// usbp_host_bridge
// Command bridge between an FX2 slave-FIFO interface and the board peripherals.
// Opcodes come in from EP2 OUT. Responses go back to EP6 IN as one-byte packets.
// The peripherals are an LED register, a chip-select register and a mode-0 SPI master.
//
// state  | meaning
// -------+---------------------------------------------------------------
// RD_OP  | fetch opcode byte from EP2 OUT and dispatch on it
// RD_ARG | fetch argument byte from EP2 OUT
// EXEC   | apply LED/SS write or load the SPI shifter
// SPI    | 8-bit mode-0 transfer, 4 IFCLK cycles per bit
// WR     | write response byte to EP6 IN once FLAGB allows
// PKT    | pulse PKTEND to commit the one-byte packet
module usbp_host_bridge (
    input  logic       reset,
    input  logic       IFCLK,
    input  logic       sys_clk,
    input  logic       FLAGA,
    input  logic       FLAGB,
    input  logic       FLAGC,
    input  logic       FLAGD,
    output logic       SLOE,
    output logic       SLRD,
    output logic       SLWR,
    output logic [1:0] FIFOADR,
    output logic       PKTEND,
    input  logic [7:0] FDI,
    output logic [7:0] FDO,
    output logic [7:0] LEDs,
    output logic [7:0] SS,
    output logic       SCK,
    output logic       MOSI,
    input  logic       MISO,
    input  logic       SCL_i,
    input  logic       SCL_o,
    input  logic       SDA_i,
    input  logic       SDA_o
);

    typedef enum logic [2:0] {
        RD_OP  = 3'd0,
        RD_ARG = 3'd1,
        EXEC   = 3'd2,
        SPI    = 3'd3,
        WR     = 3'd4,
        PKT    = 3'd5
    } state_t;

    localparam logic [7:0] OP_LED_WR = 8'h01;
    localparam logic [7:0] OP_LED_RD = 8'h02;
    localparam logic [7:0] OP_SS_WR  = 8'h03;
    localparam logic [7:0] OP_SPI    = 8'h04;
    localparam logic [7:0] OP_ID     = 8'h05;
    localparam logic [7:0] ID_BYTE   = 8'hA5;
    localparam logic [1:0] ADR_EP2   = 2'b00;
    localparam logic [1:0] ADR_EP6   = 2'b10;

    state_t      r_state;
    logic        r_sloe;
    logic        r_slrd;
    logic        r_slwr;
    logic [1:0]  r_fifoadr;
    logic        r_pktend;
    logic [7:0]  r_fdo;
    logic [7:0]  r_leds;
    logic [7:0]  r_ss;
    logic        r_sck;
    logic        r_mosi;
    logic [7:0]  r_op;
    logic [7:0]  r_arg;
    logic [7:0]  r_shift;
    logic [4:0]  r_cnt;

    logic        w_rd_ready;
    logic        w_wr_ready;
    logic        w_sck_rise;
    logic        w_sck_fall;
    logic        w_unused;

    // A strobe may only be raised once the registered address/OE already
    // point at the right FIFO, so they lead the strobe by a cycle.
    assign w_rd_ready = !r_sloe && (r_fifoadr == ADR_EP2);
    assign w_wr_ready =  r_sloe && (r_fifoadr == ADR_EP6);

    // r_cnt counts 31..0 through the transfer; its low two bits give the
    // SCK phase: 3,2 = low half, 1,0 = high half.
    assign w_sck_rise = (r_cnt[1:0] == 2'd2);
    assign w_sck_fall = (r_cnt[1:0] == 2'd0);

    assign w_unused = &{1'b0, sys_clk, FLAGC, FLAGD, SCL_i, SCL_o, SDA_i, SDA_o};

    assign SLOE    = r_sloe;
    assign SLRD    = r_slrd;
    assign SLWR    = r_slwr;
    assign FIFOADR = r_fifoadr;
    assign PKTEND  = r_pktend;
    assign FDO     = r_fdo;
    assign LEDs    = r_leds;
    assign SS      = r_ss;
    assign SCK     = r_sck;
    assign MOSI    = r_mosi;

    // Command FSM with all FX2 strobes, peripheral registers and SPI shifter
    always_ff @(posedge IFCLK or posedge reset) begin
        if (reset) begin
            r_state   <= RD_OP;
            r_sloe    <= 1'b1;
            r_slrd    <= 1'b1;
            r_slwr    <= 1'b1;
            r_fifoadr <= ADR_EP2;
            r_pktend  <= 1'b1;
            r_fdo     <= 8'h00;
            r_leds    <= 8'h00;
            r_ss      <= 8'hFF;
            r_sck     <= 1'b0;
            r_mosi    <= 1'b0;
            r_op      <= 8'h00;
            r_arg     <= 8'h00;
            r_shift   <= 8'h00;
            r_cnt     <= 5'd0;
        end else begin
            case (r_state)
                RD_OP: begin
                    r_fifoadr <= ADR_EP2;
                    r_sloe    <= 1'b0;
                    if (!r_slrd) begin
                        r_slrd <= 1'b1;
                        r_op   <= FDI;
                        case (FDI)
                            OP_LED_WR, OP_SS_WR, OP_SPI: r_state <= RD_ARG;
                            OP_LED_RD: begin
                                r_fdo   <= r_leds;
                                r_state <= WR;
                            end
                            OP_ID: begin
                                r_fdo   <= ID_BYTE;
                                r_state <= WR;
                            end
                            default: r_state <= RD_OP;
                        endcase
                    end else if (FLAGA && w_rd_ready) begin
                        r_slrd <= 1'b0;
                    end
                end

                RD_ARG: begin
                    r_fifoadr <= ADR_EP2;
                    r_sloe    <= 1'b0;
                    if (!r_slrd) begin
                        r_slrd  <= 1'b1;
                        r_arg   <= FDI;
                        r_state <= EXEC;
                    end else if (FLAGA && w_rd_ready) begin
                        r_slrd <= 1'b0;
                    end
                end

                EXEC: begin
                    case (r_op)
                        OP_LED_WR: begin
                            r_leds  <= r_arg;
                            r_state <= RD_OP;
                        end
                        OP_SS_WR: begin
                            r_ss    <= r_arg;
                            r_state <= RD_OP;
                        end
                        OP_SPI: begin
                            r_shift <= r_arg;
                            r_mosi  <= r_arg[7];
                            r_sck   <= 1'b0;
                            r_cnt   <= 5'd31;
                            r_state <= SPI;
                        end
                        default: r_state <= RD_OP;
                    endcase
                end

                SPI: begin
                    r_cnt <= r_cnt - 5'd1;
                    if (w_sck_rise) begin
                        r_sck   <= 1'b1;
                        r_shift <= {r_shift[6:0], MISO};
                    end else if (w_sck_fall) begin
                        r_sck <= 1'b0;
                        if (r_cnt == 5'd0) begin
                            // Last falling edge: MOSI keeps its final bit.
                            r_fdo   <= r_shift;
                            r_state <= WR;
                        end else begin
                            r_mosi <= r_shift[7];
                        end
                    end
                end

                WR: begin
                    r_fifoadr <= ADR_EP6;
                    r_sloe    <= 1'b1;
                    if (!r_slwr) begin
                        r_slwr   <= 1'b1;
                        r_pktend <= 1'b0;
                        r_state  <= PKT;
                    end else if (FLAGB && w_wr_ready) begin
                        r_slwr <= 1'b0;
                    end
                end

                PKT: begin
                    r_pktend <= 1'b1;
                    r_state  <= RD_OP;
                end

                default: begin
                    r_slrd   <= 1'b1;
                    r_slwr   <= 1'b1;
                    r_pktend <= 1'b1;
                    r_state  <= RD_OP;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_usbp_host_bridge.sv
// Testbench for usbp_host_bridge: FX2 FIFO model feeding command bytes,
// expected response bytes kept in a scoreboard queue and checked at each SLWR.
module tb_usbp_host_bridge;

    logic       reset;
    logic       IFCLK;
    logic       sys_clk;
    logic       FLAGA;
    logic       FLAGB;
    logic       FLAGC;
    logic       FLAGD;
    logic       SLOE;
    logic       SLRD;
    logic       SLWR;
    logic [1:0] FIFOADR;
    logic       PKTEND;
    logic [7:0] FDI;
    logic [7:0] FDO;
    logic [7:0] LEDs;
    logic [7:0] SS;
    logic       SCK;
    logic       MOSI;
    logic       MISO;
    logic       SCL_i, SCL_o, SDA_i, SDA_o;

    logic       loop_en;
    logic       flaga_en;
    logic       rd_pend;
    logic       prev_sck;

    logic [7:0] fifo_q[$];
    logic [7:0] sb_q[$];

    int n_checks;
    int n_pass;
    int cyc;
    int slrd_low_cnt;
    int slwr_cnt;
    int rd_bad_cnt;
    int wr_bad_cnt;
    int sck_rises;
    int sck_last_rise;
    int sck_bad_period;

    usbp_host_bridge dut (
        .reset   (reset),
        .IFCLK   (IFCLK),
        .sys_clk (sys_clk),
        .FLAGA   (FLAGA),
        .FLAGB   (FLAGB),
        .FLAGC   (FLAGC),
        .FLAGD   (FLAGD),
        .SLOE    (SLOE),
        .SLRD    (SLRD),
        .SLWR    (SLWR),
        .FIFOADR (FIFOADR),
        .PKTEND  (PKTEND),
        .FDI     (FDI),
        .FDO     (FDO),
        .LEDs    (LEDs),
        .SS      (SS),
        .SCK     (SCK),
        .MOSI    (MOSI),
        .MISO    (MISO),
        .SCL_i   (SCL_i),
        .SCL_o   (SCL_o),
        .SDA_i   (SDA_i),
        .SDA_o   (SDA_o)
    );

    assign MISO = loop_en ? MOSI : 1'b0;

    initial IFCLK = 1'b0;
    always #5 IFCLK = ~IFCLK;
    initial sys_clk = 1'b0;
    always #7 sys_clk = ~sys_clk;

    // FX2 EP2 OUT model: a byte strobed out during a cycle is retired on the
    // following falling edge; unused pins get random noise.
    always @(negedge IFCLK) begin
        if (reset) begin
            rd_pend = 1'b0;
        end else begin
            if (rd_pend && fifo_q.size() != 0) void'(fifo_q.pop_front());
            rd_pend = (SLRD === 1'b0);
        end
        FDI   = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
        FLAGA = flaga_en && (fifo_q.size() != 0);
        FLAGC = 1'($urandom);
        FLAGD = 1'($urandom);
        SCL_i = 1'($urandom);
        SCL_o = 1'($urandom);
        SDA_i = 1'($urandom);
        SDA_o = 1'($urandom);
    end

    // Bus activity counters
    always @(negedge IFCLK) begin
        cyc = cyc + 1;
        if (SLRD === 1'b0) begin
            slrd_low_cnt = slrd_low_cnt + 1;
            if (FIFOADR !== 2'b00 || SLOE !== 1'b0) rd_bad_cnt = rd_bad_cnt + 1;
        end
        if (SLWR === 1'b0) begin
            slwr_cnt = slwr_cnt + 1;
            if (FIFOADR !== 2'b10 || SLOE !== 1'b1) wr_bad_cnt = wr_bad_cnt + 1;
        end
        if (SCK === 1'b1 && prev_sck === 1'b0) begin
            sck_rises = sck_rises + 1;
            if (sck_last_rise >= 0 && (cyc - sck_last_rise) != 4)
                sck_bad_period = sck_bad_period + 1;
            sck_last_rise = cyc;
        end
        prev_sck = SCK;
    end

    task automatic push_byte(input logic [7:0] b);
        @(posedge IFCLK);
        #1;
        fifo_q.push_back(b);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge IFCLK);
    endtask

    task automatic wait_response(input string name);
        int  n;
        bit  got;
        logic [7:0] exp;
        n   = 0;
        got = 0;
        while (n < 300 && !got) begin
            @(negedge IFCLK);
            if (SLWR === 1'b0) got = 1;
            else n++;
        end
        n_checks++;
        if (!got) begin
            $display("FAIL %s_slwr: no SLWR pulse within 300 cycles", name);
        end else if (sb_q.size() == 0) begin
            $display("FAIL %s_sb: SLWR pulse with FDO=%02h but nothing expected", name, FDO);
        end else begin
            exp = sb_q.pop_front();
            if (FDO !== exp) $display("FAIL %s_fdo: got %02h expected %02h", name, FDO, exp);
            else n_pass++;
            n_checks++;
            if (FIFOADR !== 2'b10) $display("FAIL %s_fifoadr: got %b expected 10", name, FIFOADR);
            else n_pass++;
            @(negedge IFCLK);
            n_checks++;
            if (PKTEND !== 1'b0 || SLWR !== 1'b1)
                $display("FAIL %s_pktend: got PKTEND=%b SLWR=%b expected 0 1", name, PKTEND, SLWR);
            else n_pass++;
            @(negedge IFCLK);
            n_checks++;
            if (PKTEND !== 1'b1) $display("FAIL %s_pktend_end: got %b expected 1", name, PKTEND);
            else n_pass++;
        end
    endtask

    task automatic wait_drained(input string name);
        int n;
        n = 0;
        while (n < 300 && fifo_q.size() != 0) begin
            @(negedge IFCLK);
            n++;
        end
        n_checks++;
        if (fifo_q.size() != 0) $display("FAIL %s_drain: %0d bytes left unread", name, fifo_q.size());
        else n_pass++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        wait_cycles(3);
        n_checks++;
        if ({SLOE, SLRD, SLWR, PKTEND} !== 4'b1111)
            $display("FAIL reset_strobes: got %b expected 1111", {SLOE, SLRD, SLWR, PKTEND});
        else n_pass++;
        n_checks++;
        if (FIFOADR !== 2'b00 || FDO !== 8'h00)
            $display("FAIL reset_bus: got FIFOADR=%b FDO=%02h expected 00 00", FIFOADR, FDO);
        else n_pass++;
        n_checks++;
        if (LEDs !== 8'h00 || SS !== 8'hFF)
            $display("FAIL reset_regs: got LEDs=%02h SS=%02h expected 00 FF", LEDs, SS);
        else n_pass++;
        n_checks++;
        if (SCK !== 1'b0 || MOSI !== 1'b0)
            $display("FAIL reset_spi: got SCK=%b MOSI=%b expected 0 0", SCK, MOSI);
        else n_pass++;
        reset = 1'b0;
        wait_cycles(4);
    endtask

    task automatic test_led();
        int w0;
        w0 = slwr_cnt;
        sb_q.push_back(8'h3C);
        push_byte(8'h01);
        push_byte(8'h3C);
        push_byte(8'h02);
        wait_response("led");
        wait_cycles(5);
        n_checks++;
        if (LEDs !== 8'h3C) $display("FAIL led_reg: got %02h expected 3C", LEDs);
        else n_pass++;
        n_checks++;
        if (slwr_cnt - w0 != 1) $display("FAIL led_slwr_count: got %0d expected 1", slwr_cnt - w0);
        else n_pass++;
        n_checks++;
        if (rd_bad_cnt != 0) $display("FAIL led_rd_addr: %0d read strobes with wrong FIFOADR/SLOE, expected 0", rd_bad_cnt);
        else n_pass++;
    endtask

    task automatic test_spi();
        int r0;
        loop_en       = 1'b1;
        sck_last_rise = -1;
        sck_bad_period = 0;
        r0 = sck_rises;
        sb_q.push_back(8'h96);
        push_byte(8'h03);
        push_byte(8'hFE);
        push_byte(8'h04);
        push_byte(8'h96);
        wait_response("spi");
        n_checks++;
        if (SS !== 8'hFE) $display("FAIL spi_ss: got %02h expected FE", SS);
        else n_pass++;
        n_checks++;
        if (sck_rises - r0 != 8) $display("FAIL spi_sck_pulses: got %0d expected 8", sck_rises - r0);
        else n_pass++;
        n_checks++;
        if (sck_bad_period != 0) $display("FAIL spi_sck_period: %0d periods not 4 cycles, expected 0", sck_bad_period);
        else n_pass++;
        n_checks++;
        if (SCK !== 1'b0) $display("FAIL spi_sck_idle: got %b expected 0", SCK);
        else n_pass++;
    endtask

    task automatic test_flow();
        int w0;
        FLAGB = 1'b0;
        w0 = slwr_cnt;
        sb_q.push_back(8'hA5);
        push_byte(8'h05);
        wait_cycles(10);
        n_checks++;
        if (slwr_cnt != w0) $display("FAIL flow_hold: got %0d SLWR pulses expected 0", slwr_cnt - w0);
        else n_pass++;
        FLAGB = 1'b1;
        wait_response("flow");
        n_checks++;
        if (slwr_cnt - w0 != 1) $display("FAIL flow_count: got %0d SLWR pulses expected 1", slwr_cnt - w0);
        else n_pass++;
    endtask

    task automatic test_empty_unknown();
        int r0;
        int w0;
        flaga_en = 1'b0;
        push_byte(8'h7F);
        push_byte(8'h01);
        push_byte(8'h55);
        r0 = slrd_low_cnt;
        w0 = slwr_cnt;
        wait_cycles(10);
        n_checks++;
        if (slrd_low_cnt != r0) $display("FAIL empty_slrd: got %0d read strobes expected 0", slrd_low_cnt - r0);
        else n_pass++;
        flaga_en = 1'b1;
        wait_drained("empty");
        wait_cycles(6);
        n_checks++;
        if (LEDs !== 8'h55) $display("FAIL unknown_leds: got %02h expected 55", LEDs);
        else n_pass++;
        n_checks++;
        if (slwr_cnt != w0) $display("FAIL unknown_slwr: got %0d SLWR pulses expected 0", slwr_cnt - w0);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        sb_q.push_back(8'hA5);
        sb_q.push_back(8'h55);
        sb_q.push_back(8'hA5);
        push_byte(8'h05);
        push_byte(8'h02);
        push_byte(8'h05);
        wait_response("b2b_0");
        wait_response("b2b_1");
        wait_response("b2b_2");
    endtask

    task automatic test_reset_mid_spi();
        int r0;
        int w0;
        int n;
        r0 = sck_rises;
        push_byte(8'h04);
        push_byte(8'h5A);
        n = 0;
        while (n < 300 && (sck_rises - r0) < 5) begin
            @(negedge IFCLK);
            #1;
            n++;
        end
        n_checks++;
        if (SCK !== 1'b1) $display("FAIL midspi_reach: got SCK=%b after %0d rises, expected 1", SCK, sck_rises - r0);
        else n_pass++;
        #1;
        reset = 1'b1;
        w0 = slwr_cnt;
        #1;
        n_checks++;
        if (SCK !== 1'b0 || SLWR !== 1'b1 || PKTEND !== 1'b1)
            $display("FAIL midspi_async: got SCK=%b SLWR=%b PKTEND=%b expected 0 1 1", SCK, SLWR, PKTEND);
        else n_pass++;
        n_checks++;
        if (SS !== 8'hFF || LEDs !== 8'h00)
            $display("FAIL midspi_regs: got SS=%02h LEDs=%02h expected FF 00", SS, LEDs);
        else n_pass++;
        wait_cycles(2);
        reset = 1'b0;
        wait_cycles(40);
        n_checks++;
        if (slwr_cnt != w0) $display("FAIL midspi_no_write: got %0d SLWR pulses expected 0", slwr_cnt - w0);
        else n_pass++;
        sb_q.push_back(8'hA5);
        push_byte(8'h05);
        wait_response("after_reset");
    endtask

    initial begin
        n_checks       = 0;
        n_pass         = 0;
        cyc            = 0;
        slrd_low_cnt   = 0;
        slwr_cnt       = 0;
        rd_bad_cnt     = 0;
        wr_bad_cnt     = 0;
        sck_rises      = 0;
        sck_last_rise  = -1;
        sck_bad_period = 0;
        prev_sck       = 1'b0;
        rd_pend        = 1'b0;
        loop_en        = 1'b0;
        flaga_en       = 1'b1;
        reset          = 1'b1;
        FLAGB          = 1'b1;

        test_reset();
        test_led();
        test_spi();
        test_flow();
        test_empty_unknown();
        test_back_to_back();
        test_reset_mid_spi();

        n_checks++;
        if (wr_bad_cnt != 0) $display("FAIL wr_addr: %0d write strobes with wrong FIFOADR/SLOE, expected 0", wr_bad_cnt);
        else n_pass++;
        n_checks++;
        if (sb_q.size() != 0) $display("FAIL sb_leftover: %0d responses never seen, expected 0", sb_q.size());
        else n_pass++;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
